sample_and_hold_mux: RTL and testbench
======================================

# sample_and_hold_mux

Parametrised multi-channel successor to the single-channel sample-and-hold in the SAR ADC model. It tracks one of `NUM_CH` analog-code inputs and, on request, runs a timed acquisition window before freezing the value. It holds the value for the SAR conversion until released and can model capacitor droop during hold. It sits between the analog input bus and the SAR comparator/DAC loop, and supports back-to-back conversions across channels.

## Interface
Parameters:
- `WIDTH`, 10, bit width of each channel's voltage code.
- `NUM_CH`, 4, number of input channels (≥1).
- `ACQ_CYCLES`, 4, acquisition window length in clk cycles (1..255).
- `DROOP_PERIOD`, 0, hold cycles per 1-LSB droop step; 0 disables droop (0..65535).
- Derived: `CH_W` = max(1, clog2(`NUM_CH`)).

Ports:
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `input_voltage_real`  in  `NUM_CH*WIDTH`  channel codes; channel i is bits [i*WIDTH +: WIDTH].
- `ch_sel`  in  `CH_W`  channel to track or sample.
- `sample_req`  in  1  start acquisition; sampled only in IDLE, or in HOLD together with `hold_release`.
- `hold_release`  in  1  end of hold (SAR conversion done); sampled only in HOLD.
- `output_voltage_real`  out  `WIDTH`  capacitor value (registered).
- `held_ch`  out  `CH_W`  channel latched at the last accepted request.
- `busy`  out  1  high in ACQUIRE or HOLD.
- `hold_valid`  out  1  high in HOLD; the output is frozen, apart from droop.

## Operation
- Reset (async, high): state IDLE; cap, acq counter, droop counter and `held_ch` go to 0; `hold_valid` and `busy` go to 0. All outputs reach these values immediately, without a clk edge.
- Channel mux: selected code = channel[sel] when sel < `NUM_CH`, otherwise 0.
- IDLE, the track state:
  - Each edge: cap <= channel[`ch_sel`].
  - On `sample_req`: `held_ch` <= `ch_sel`, acq counter <= 0, go to ACQUIRE.
- ACQUIRE:
  - Each edge: cap <= channel[`held_ch`] and the acq counter increments.
  - Changes on `ch_sel` are ignored. `sample_req` is ignored.
  - At the edge where acq counter == `ACQ_CYCLES`-1: make the final capture, go to HOLD, `hold_valid` <= 1, droop counter <= 0.
- HOLD:
  - cap is frozen.
  - If `DROOP_PERIOD` > 0: the droop counter increments each edge. At the edge where it equals `DROOP_PERIOD`-1, cap <= cap-1 (saturating at 0) and the counter clears.
  - On `hold_release` without `sample_req`: go to IDLE, `hold_valid` <= 0. No droop or tracking at that edge.
  - On `hold_release` with `sample_req` (back-to-back): go directly to ACQUIRE, `held_ch` <= `ch_sel`, acq counter <= 0, `hold_valid` <= 0. `busy` stays 1. cap resumes tracking from the next edge.
  - `sample_req` alone is ignored.
- `busy` = (state != IDLE). `hold_valid` = (state == HOLD).
- Width rules:
  - All cap arithmetic is `WIDTH`-bit unsigned; droop never wraps below 0.
  - The acq counter is 8 bits; the droop counter is 16 bits.

## Timing
- Tracking latency: the output follows the selected input with a 1-cycle register lag.
- `sample_req` sampled high at edge k (in IDLE):
  - ACQUIRE occupies edges k+1 .. k+`ACQ_CYCLES`.
  - `busy` is high after edge k.
  - After edge k+`ACQ_CYCLES`: `hold_valid` is high, and the held value equals the channel code present at edge k+`ACQ_CYCLES`.
- With `ACQ_CYCLES`=1, `hold_valid` rises one edge after the accepted request.
- First droop step lands `DROOP_PERIOD` edges after `hold_valid` rises, then one step every `DROOP_PERIOD` edges.
- `hold_release` at edge r:
  - `hold_valid` is low after edge r.
  - Release alone: `busy` is low after edge r, and IDLE tracking updates cap from edge r+1.
- Reset asserted mid-ACQUIRE or mid-HOLD aborts immediately. After deassertion the block is in IDLE and tracks from the first edge.

## Test plan
- Async reset: force HOLD with cap=10'd512, then assert `reset` between edges. The output goes to 0 and `busy`, `hold_valid` and `held_ch` go to 0 with no clk edge.
- Acquire/hold (defaults): ch1=300, `ch_sel`=1, `sample_req` at edge k. `hold_valid` rises after k+4. Set ch1=700 at k+5: the output stays 300 until `hold_release`, then reads 700 one edge after tracking resumes.
- Droop, with `DROOP_PERIOD`=8 and a held value of 3: the output reads 2 after 8 edges, 1 after 16, 0 after 24, and stays 0 at 32 (no wrap).
- Back-to-back: in HOLD on ch1, assert `hold_release` and `sample_req` with `ch_sel`=2 (ch2=123) on the same edge. `busy` stays 1, `hold_valid` is low for 4 edges, then high with output 123 and `held_ch`=2.
- Ignored inputs: `sample_req` and `ch_sel` changes during ACQUIRE, and `sample_req` alone during HOLD, leave state, `held_ch` and timing unchanged.
- Corner case, `NUM_CH`=3, `ACQ_CYCLES`=1: `ch_sel`=3 with a request gives held output 0 and `held_ch`=3, and `hold_valid` rises one edge after the request.

Source files
------------

// File: rtl/sample_and_hold_mux.sv
// Purpose: multi-channel sample-and-hold. Tracks the selected channel in IDLE,
//          runs a fixed acquisition window on request, then holds the value
//          (with optional 1-LSB droop) until released by the SAR loop.
// Latency: output is registered, 1-cycle lag while tracking; the held value is
//          valid ACQ_CYCLES edges after an accepted request.
// Backpressure: none; requests outside IDLE (or HOLD+release) are dropped.
//
// Ports:
//   clk                 clock, rising edge
//   reset               asynchronous active-high reset
//   input_voltage_real  NUM_CH packed channel codes, channel i at [i*WIDTH +: WIDTH]
//   ch_sel              channel to track / sample
//   sample_req          start acquisition (IDLE, or HOLD together with hold_release)
//   hold_release        end of hold (HOLD only)
//   output_voltage_real capacitor value
//   held_ch             channel latched at the last accepted request
//   busy                high in ACQUIRE or HOLD
//   hold_valid          high in HOLD
module sample_and_hold_mux #(
  parameter int WIDTH        = 10,
  parameter int NUM_CH       = 4,
  parameter int ACQ_CYCLES   = 4,
  parameter int DROOP_PERIOD = 0,
  localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CH*WIDTH-1:0] input_voltage_real,
  input  logic [CH_W-1:0]         ch_sel,
  input  logic                    sample_req,
  input  logic                    hold_release,
  output logic [WIDTH-1:0]        output_voltage_real,
  output logic [CH_W-1:0]         held_ch,
  output logic                    busy,
  output logic                    hold_valid
);

  localparam logic [7:0]  ACQ_LAST   = 8'(ACQ_CYCLES - 1);
  localparam logic [15:0] DROOP_LAST = (DROOP_PERIOD > 0) ? 16'(DROOP_PERIOD - 1) : 16'd0;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACQUIRE = 2'd1,
    S_HOLD    = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [WIDTH-1:0]   r_cap;
  logic [7:0]         r_acq_cnt;
  logic [15:0]        r_droop_cnt;
  logic [CH_W-1:0]    r_held_ch;
  logic [WIDTH-1:0]   w_sel_code;
  logic [WIDTH-1:0]   w_held_code;
  logic               w_acq_done;

  // Channel muxes; an out-of-range selector (NUM_CH not a power of two) reads 0.
  always_comb begin
    w_sel_code  = '0;
    w_held_code = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_sel == CH_W'(i))
        w_sel_code = input_voltage_real[i*WIDTH +: WIDTH];
      if (r_held_ch == CH_W'(i))
        w_held_code = input_voltage_real[i*WIDTH +: WIDTH];
    end
  end

  assign w_acq_done = (r_acq_cnt == ACQ_LAST);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_state <= S_IDLE;
    else
      r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (sample_req)
          w_next_state = S_ACQUIRE;
      end
      S_ACQUIRE: begin
        if (w_acq_done)
          w_next_state = S_HOLD;
      end
      S_HOLD: begin
        if (hold_release)
          w_next_state = sample_req ? S_ACQUIRE : S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Outputs decoded from state so reset clears them without a clock edge.
  always_comb begin
    busy       = (r_state != S_IDLE);
    hold_valid = (r_state == S_HOLD);
  end

  // Capacitor, counters and latched channel.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cap       <= '0;
      r_acq_cnt   <= '0;
      r_droop_cnt <= '0;
      r_held_ch   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cap <= w_sel_code;
          if (sample_req) begin
            r_held_ch <= ch_sel;
            r_acq_cnt <= '0;
          end
        end
        S_ACQUIRE: begin
          // Last edge of the window is also the final capture.
          r_cap     <= w_held_code;
          r_acq_cnt <= r_acq_cnt + 8'd1;
          if (w_acq_done)
            r_droop_cnt <= '0;
        end
        S_HOLD: begin
          if (hold_release) begin
            // Cap stays frozen on the release edge; tracking resumes next edge.
            if (sample_req) begin
              r_held_ch <= ch_sel;
              r_acq_cnt <= '0;
            end
          end else if (DROOP_PERIOD > 0) begin
            if (r_droop_cnt == DROOP_LAST) begin
              r_droop_cnt <= '0;
              if (r_cap != '0)
                r_cap <= r_cap - WIDTH'(1);
            end else begin
              r_droop_cnt <= r_droop_cnt + 16'd1;
            end
          end
        end
        default: begin
          r_cap <= r_cap;
        end
      endcase
    end
  end

  assign output_voltage_real = r_cap;
  assign held_ch             = r_held_ch;

endmodule

// File: tb/tb_sample_and_hold_mux.sv
module tb_sample_and_hold_mux;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // dut0: defaults (4 ch, ACQ 4, no droop)
  logic [39:0] in0;
  logic [1:0]  sel0;
  logic        req0, rel0;
  logic [9:0]  out0;
  logic [1:0]  held0;
  logic        busy0, hv0;

  // dut1: droop every 8 hold cycles
  logic [39:0] in1;
  logic [1:0]  sel1;
  logic        req1, rel1;
  logic [9:0]  out1;
  logic [1:0]  held1;
  logic        busy1, hv1;

  // dut2: 3 channels, ACQ 1
  logic [29:0] in2;
  logic [1:0]  sel2;
  logic        req2, rel2;
  logic [9:0]  out2;
  logic [1:0]  held2;
  logic        busy2, hv2;

  sample_and_hold_mux dut0 (
    .clk(clk), .reset(reset), .input_voltage_real(in0), .ch_sel(sel0),
    .sample_req(req0), .hold_release(rel0), .output_voltage_real(out0),
    .held_ch(held0), .busy(busy0), .hold_valid(hv0));

  sample_and_hold_mux #(.DROOP_PERIOD(8)) dut1 (
    .clk(clk), .reset(reset), .input_voltage_real(in1), .ch_sel(sel1),
    .sample_req(req1), .hold_release(rel1), .output_voltage_real(out1),
    .held_ch(held1), .busy(busy1), .hold_valid(hv1));

  sample_and_hold_mux #(.NUM_CH(3), .ACQ_CYCLES(1)) dut2 (
    .clk(clk), .reset(reset), .input_voltage_real(in2), .ch_sel(sel2),
    .sample_req(req2), .hold_release(rel2), .output_voltage_real(out2),
    .held_ch(held2), .busy(busy2), .hold_valid(hv2));

  // Advance one rising edge; inputs change and outputs are sampled 1 time unit later.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    in0 = '0; sel0 = '0; req0 = 0; rel0 = 0;
    in1 = '0; sel1 = '0; req1 = 0; rel1 = 0;
    in2 = '0; sel2 = '0; req2 = 0; rel2 = 0;
    reset = 1'b1;
    #1;
    n_total++; if (out0 !== 10'd0) $display("FAIL reset_out: got %0d expected 0", out0); else n_pass++;
    n_total++; if (busy0 !== 1'b0) $display("FAIL reset_busy: got %0b expected 0", busy0); else n_pass++;
    n_total++; if (hv0 !== 1'b0) $display("FAIL reset_hold_valid: got %0b expected 0", hv0); else n_pass++;
    n_total++; if (held0 !== 2'd0) $display("FAIL reset_held_ch: got %0d expected 0", held0); else n_pass++;
    tick(2);
    reset = 1'b0;
  endtask

  task automatic test_tracking;
    in0[20 +: 10] = 10'd55; sel0 = 2'd2;
    tick();
    n_total++; if (out0 !== 10'd55) $display("FAIL track_a: got %0d expected 55", out0); else n_pass++;
    in0[20 +: 10] = 10'd66;
    n_total++; if (out0 !== 10'd55) $display("FAIL track_lag: got %0d expected 55", out0); else n_pass++;
    tick();
    n_total++; if (out0 !== 10'd66) $display("FAIL track_b: got %0d expected 66", out0); else n_pass++;
    n_total++; if (busy0 !== 1'b0) $display("FAIL track_busy: got %0b expected 0", busy0); else n_pass++;
  endtask

  task automatic test_acquire_hold;
    in0[10 +: 10] = 10'd300; sel0 = 2'd1; req0 = 1;
    tick();  // edge k
    req0 = 0;
    n_total++; if (busy0 !== 1'b1) $display("FAIL acq_busy: got %0b expected 1", busy0); else n_pass++;
    n_total++; if (hv0 !== 1'b0) $display("FAIL acq_hv_k: got %0b expected 0", hv0); else n_pass++;
    tick(3);  // k+3
    n_total++; if (hv0 !== 1'b0) $display("FAIL acq_hv_k3: got %0b expected 0", hv0); else n_pass++;
    tick();  // k+4
    n_total++; if (hv0 !== 1'b1) $display("FAIL acq_hv_k4: got %0b expected 1", hv0); else n_pass++;
    n_total++; if (out0 !== 10'd300) $display("FAIL acq_held_val: got %0d expected 300", out0); else n_pass++;
    n_total++; if (held0 !== 2'd1) $display("FAIL acq_held_ch: got %0d expected 1", held0); else n_pass++;
    in0[10 +: 10] = 10'd700;
    tick(3);
    n_total++; if (out0 !== 10'd300) $display("FAIL hold_frozen: got %0d expected 300", out0); else n_pass++;
    // sample_req alone in HOLD is ignored
    req0 = 1; sel0 = 2'd3;
    tick(2);
    req0 = 0; sel0 = 2'd1;
    n_total++; if (hv0 !== 1'b1) $display("FAIL hold_req_ignored_hv: got %0b expected 1", hv0); else n_pass++;
    n_total++; if (held0 !== 2'd1) $display("FAIL hold_req_ignored_ch: got %0d expected 1", held0); else n_pass++;
    n_total++; if (out0 !== 10'd300) $display("FAIL hold_req_ignored_val: got %0d expected 300", out0); else n_pass++;
    rel0 = 1;
    tick();  // edge r
    rel0 = 0;
    n_total++; if (hv0 !== 1'b0) $display("FAIL rel_hv: got %0b expected 0", hv0); else n_pass++;
    n_total++; if (busy0 !== 1'b0) $display("FAIL rel_busy: got %0b expected 0", busy0); else n_pass++;
    n_total++; if (out0 !== 10'd300) $display("FAIL rel_edge_val: got %0d expected 300", out0); else n_pass++;
    tick();  // r+1
    n_total++; if (out0 !== 10'd700) $display("FAIL rel_track: got %0d expected 700", out0); else n_pass++;
  endtask

  task automatic test_ignored_in_acquire;
    in0[10 +: 10] = 10'd200; in0[30 +: 10] = 10'd999; sel0 = 2'd1; req0 = 1;
    tick();  // edge k
    sel0 = 2'd3;  // req0 stays high, sel changes: both ignored in ACQUIRE
    tick(3);
    n_total++; if (hv0 !== 1'b0) $display("FAIL ign_hv_k3: got %0b expected 0", hv0); else n_pass++;
    req0 = 0;
    tick();  // k+4
    n_total++; if (hv0 !== 1'b1) $display("FAIL ign_hv_k4: got %0b expected 1", hv0); else n_pass++;
    n_total++; if (held0 !== 2'd1) $display("FAIL ign_held_ch: got %0d expected 1", held0); else n_pass++;
    n_total++; if (out0 !== 10'd200) $display("FAIL ign_val: got %0d expected 200", out0); else n_pass++;
  endtask

  task automatic test_back_to_back;
    // still in HOLD on ch1 from previous task
    in0[20 +: 10] = 10'd123; sel0 = 2'd2; req0 = 1; rel0 = 1;
    tick();  // edge r
    req0 = 0; rel0 = 0;
    n_total++; if (busy0 !== 1'b1) $display("FAIL b2b_busy: got %0b expected 1", busy0); else n_pass++;
    n_total++; if (hv0 !== 1'b0) $display("FAIL b2b_hv_r: got %0b expected 0", hv0); else n_pass++;
    n_total++; if (held0 !== 2'd2) $display("FAIL b2b_held_ch_r: got %0d expected 2", held0); else n_pass++;
    tick(3);
    n_total++; if (hv0 !== 1'b0) $display("FAIL b2b_hv_r3: got %0b expected 0", hv0); else n_pass++;
    n_total++; if (busy0 !== 1'b1) $display("FAIL b2b_busy_r3: got %0b expected 1", busy0); else n_pass++;
    tick();
    n_total++; if (hv0 !== 1'b1) $display("FAIL b2b_hv_r4: got %0b expected 1", hv0); else n_pass++;
    n_total++; if (out0 !== 10'd123) $display("FAIL b2b_val: got %0d expected 123", out0); else n_pass++;
    n_total++; if (held0 !== 2'd2) $display("FAIL b2b_held_ch: got %0d expected 2", held0); else n_pass++;
  endtask

  task automatic test_droop;
    in1[0 +: 10] = 10'd3; sel1 = 2'd0; req1 = 1;
    tick();
    req1 = 0;
    tick(4);  // hold_valid rises here
    n_total++; if (hv1 !== 1'b1) $display("FAIL droop_hv: got %0b expected 1", hv1); else n_pass++;
    n_total++; if (out1 !== 10'd3) $display("FAIL droop_0: got %0d expected 3", out1); else n_pass++;
    tick(7);
    n_total++; if (out1 !== 10'd3) $display("FAIL droop_7: got %0d expected 3", out1); else n_pass++;
    tick();
    n_total++; if (out1 !== 10'd2) $display("FAIL droop_8: got %0d expected 2", out1); else n_pass++;
    tick(8);
    n_total++; if (out1 !== 10'd1) $display("FAIL droop_16: got %0d expected 1", out1); else n_pass++;
    tick(8);
    n_total++; if (out1 !== 10'd0) $display("FAIL droop_24: got %0d expected 0", out1); else n_pass++;
    tick(8);
    n_total++; if (out1 !== 10'd0) $display("FAIL droop_32_nowrap: got %0d expected 0", out1); else n_pass++;
    n_total++; if (hv1 !== 1'b1) $display("FAIL droop_hv_end: got %0b expected 1", hv1); else n_pass++;
  endtask

  task automatic test_corner_out_of_range;
    in2 = {10'd777, 10'd555, 10'd333}; sel2 = 2'd0;
    tick();
    n_total++; if (out2 !== 10'd333) $display("FAIL corner_track: got %0d expected 333", out2); else n_pass++;
    sel2 = 2'd3; req2 = 1;
    tick();  // edge k
    req2 = 0;
    n_total++; if (busy2 !== 1'b1) $display("FAIL corner_busy: got %0b expected 1", busy2); else n_pass++;
    n_total++; if (hv2 !== 1'b0) $display("FAIL corner_hv_k: got %0b expected 0", hv2); else n_pass++;
    tick();  // k+1
    n_total++; if (hv2 !== 1'b1) $display("FAIL corner_hv_k1: got %0b expected 1", hv2); else n_pass++;
    n_total++; if (out2 !== 10'd0) $display("FAIL corner_val: got %0d expected 0", out2); else n_pass++;
    n_total++; if (held2 !== 2'd3) $display("FAIL corner_held_ch: got %0d expected 3", held2); else n_pass++;
  endtask

  task automatic test_async_reset_mid_hold;
    rel0 = 1;
    tick();
    rel0 = 0;
    in0[30 +: 10] = 10'd512; sel0 = 2'd3; req0 = 1;
    tick();
    req0 = 0;
    tick(4);
    n_total++; if (out0 !== 10'd512) $display("FAIL arst_pre_val: got %0d expected 512", out0); else n_pass++;
    n_total++; if (hv0 !== 1'b1) $display("FAIL arst_pre_hv: got %0b expected 1", hv0); else n_pass++;
    #2 reset = 1'b1;  // between edges
    #1;
    n_total++; if (out0 !== 10'd0) $display("FAIL arst_out: got %0d expected 0", out0); else n_pass++;
    n_total++; if (busy0 !== 1'b0) $display("FAIL arst_busy: got %0b expected 0", busy0); else n_pass++;
    n_total++; if (hv0 !== 1'b0) $display("FAIL arst_hv: got %0b expected 0", hv0); else n_pass++;
    n_total++; if (held0 !== 2'd0) $display("FAIL arst_held_ch: got %0d expected 0", held0); else n_pass++;
    tick();
    reset = 1'b0;
    in0[30 +: 10] = 10'd41;
    tick();
    n_total++; if (out0 !== 10'd41) $display("FAIL arst_track: got %0d expected 41", out0); else n_pass++;
    n_total++; if (busy0 !== 1'b0) $display("FAIL arst_idle: got %0b expected 0", busy0); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_tracking();
    test_acquire_hold();
    test_ignored_in_acquire();
    test_back_to_back();
    test_droop();
    test_corner_out_of_range();
    test_async_reset_mid_hold();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
